// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int          IMEM_AW = 6;
  localparam int          PC_W    = 64;
  localparam logic [63:0] PC_STEP = 64'd4;
  localparam int          INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {instr, pc} entries.
// Storage is not reset; the pointers and count define which entries are live.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointer and occupancy tracking; flush and reset drop every live entry.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written only on push, never cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);
  assign full  = (count == CNT_FULL);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, fetches one word per cycle from a
// combinational instruction memory and hands words to decode via valid/ready.
// Optional macro FETCH_HALT_EN: stop fetching on an all-zero instruction word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [N-1:0]       imem_q,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [N-1:0]       instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
);

  localparam int EW = N + PC_W;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target_pc;
  logic            halt_q;
  logic            fetch_en;
  logic            halt_set;
  logic            push;
  logic            pop;
  logic            q_valid;
  logic            q_full;
  logic [EW-1:0]   q_head;

  assign pop       = q_valid && instr_ready;
  assign fetch_en  = !halt_q && !redirect && (!q_full || pop);
  assign target_pc = redirect_pc & ~64'd3;

`ifdef FETCH_HALT_EN
  assign halt_set = fetch_en && (imem_q == '0);
`else
  assign halt_set = 1'b0;
`endif

  assign push = fetch_en && !halt_set;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_q, pc}),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .full      (q_full)
  );

  // PC update: reset, then redirect, then sequential advance on each push.
  always_ff @(posedge clk) begin
    if (reset)         pc <= '0;
    else if (redirect) pc <= target_pc;
    else if (push)     pc <= pc + PC_STEP;
  end

  // Halt flag: set by a zero word, cleared only by redirect or reset.
  always_ff @(posedge clk) begin
    if (reset)         halt_q <= 1'b0;
    else if (redirect) halt_q <= 1'b0;
    else if (halt_set) halt_q <= 1'b1;
  end

  assign imem_addr   = pc[IMEM_AW+1:2];
  assign instr_valid = q_valid;
  // Head fields are forced to zero when the queue is empty so that
  // uninitialised storage never reaches decode.
  assign instr       = q_valid ? q_head[EW-1:PC_W] : '0;
  assign instr_pc    = q_valid ? q_head[PC_W-1:0]  : '0;
  assign halted      = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        halted;

  logic [31:0] mem [0:63];
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  assign imem_q = mem[imem_addr];

  fetch_unit #(.N(32), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Exercise program: word i = f8000000 + (i<<15) + i, with a few overrides.
    for (int i = 0; i < 64; i++) mem[i] = 32'hf8000000 + (i << 15) + i;
    mem[15] = 32'hb400004e;
    mem[18] = 32'hf803800f;
    mem[19] = 32'h00000000;

    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_pc",    instr_pc, 64'd0);
    chk("rst_addr",  {58'd0, imem_addr}, 64'd0);
    chk("rst_halt",  {63'd0, halted}, 64'd0);

    // Streaming with ready held high: one instruction per cycle
    step();
    chk("s1_valid", {63'd0, instr_valid}, 64'd1);
    chk("s1_instr", {32'd0, instr}, 64'h00000000f8000000);
    chk("s1_pc",    instr_pc, 64'd0);
    step();
    chk("s2_instr", {32'd0, instr}, 64'h00000000f8008001);
    chk("s2_pc",    instr_pc, 64'd4);
    step();
    chk("s3_instr", {32'd0, instr}, 64'h00000000f8010002);
    chk("s3_pc",    instr_pc, 64'd8);

    // Backpressure: queue fills to two entries then fetch stalls
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    chk("bp_addr",  {58'd0, imem_addr}, 64'd2);
    chk("bp_valid", {63'd0, instr_valid}, 64'd1);
    chk("bp_instr", {32'd0, instr}, 64'h00000000f8000000);
    instr_ready = 1'b1;
    #1;
    chk("bp_rel0", {32'd0, instr}, 64'h00000000f8000000);
    step();
    chk("bp_rel1", {32'd0, instr}, 64'h00000000f8008001);
    step();
    chk("bp_rel2", {32'd0, instr}, 64'h00000000f8010002);
    chk("bp_rel2_pc", instr_pc, 64'd8);

    // Redirect with queued entries; low target bits ignored
    redirect    = 1'b1;
    redirect_pc = 64'h3F;
    step();
    redirect = 1'b0;
    chk("rd_valid", {63'd0, instr_valid}, 64'd0);
    chk("rd_addr",  {58'd0, imem_addr}, 64'd15);
    step();
    chk("rd_instr", {32'd0, instr}, 64'h00000000b400004e);
    chk("rd_pc",    instr_pc, 64'h3C);

    // Redirect near the top of the 256-byte window: word address wraps
    redirect    = 1'b1;
    redirect_pc = 64'hFC;
    step();
    redirect = 1'b0;
    step();
    chk("wr_pc_fc", instr_pc, 64'hFC);
    chk("wr_instr63", {32'd0, instr}, 64'h00000000f81f803f);
    chk("wr_addr0", {58'd0, imem_addr}, 64'd0);
    step();
    chk("wr_pc_100", instr_pc, 64'h100);
    chk("wr_instr0", {32'd0, instr}, 64'h00000000f8000000);

    // 64-bit PC wrap
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect = 1'b0;
    step();
    chk("w64_pc_top", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("w64_pc_zero", instr_pc, 64'd0);
    chk("w64_instr", {32'd0, instr}, 64'h00000000f8000000);

    // Run through the zero word at 0x4C
    do_reset();
    for (int k = 0; k < 19; k++) begin
      step();
      chk("run_pc", instr_pc, 64'(4 * k));
      chk("run_instr", {32'd0, instr}, {32'd0, mem[k]});
    end
    chk("run_last", {32'd0, instr}, 64'h00000000f803800f);
    step();
`ifdef FETCH_HALT_EN
    chk("halt_flag",  {63'd0, halted}, 64'd1);
    chk("halt_valid", {63'd0, instr_valid}, 64'd0);
    chk("halt_addr",  {58'd0, imem_addr}, 64'h13);
    step();
    chk("halt_stuck", {58'd0, imem_addr}, 64'h13);
    redirect    = 1'b1;
    redirect_pc = 64'd0;
    step();
    redirect = 1'b0;
    chk("halt_clr", {63'd0, halted}, 64'd0);
    step();
    chk("halt_restart", {32'd0, instr}, 64'h00000000f8000000);
`else
    chk("zero_valid", {63'd0, instr_valid}, 64'd1);
    chk("zero_instr", {32'd0, instr}, 64'd0);
    chk("zero_pc",    instr_pc, 64'h4C);
    chk("zero_halt",  {63'd0, halted}, 64'd0);
`endif

    // Mid-operation reset while full and stalled
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'd0;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("mr_full_addr", {58'd0, imem_addr}, 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid", {63'd0, instr_valid}, 64'd0);
    chk("mr_addr",  {58'd0, imem_addr}, 64'd0);
    chk("mr_instr", {32'd0, instr}, 64'd0);
    instr_ready = 1'b1;
    step();
    chk("mr_first", {32'd0, instr}, 64'h00000000f8000000);
    chk("mr_first_pc", instr_pc, 64'd0);
    step();
    chk("mr_second", {32'd0, instr}, 64'h00000000f8008001);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
